// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver (LSB first, one stop bit) with a
// one-entry valid/ready holding register.
// Optional even parity bit is enabled by defining UART_RX_PARITY_EN; without it
// the receiver is plain 8N1 and parity_err stays low.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  // Counter values on the sample cycle: half a bit into the start bit, then
  // one full bit period between every later sample point.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
  } state_t;
`endif

  state_t           state;
  state_t           state_nxt;

  logic             rx_meta;
  logic             rxs;
  logic             rxs_prev;
  logic [1:0]       fill;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic             fall_c;
  logic             sample_c;
  logic             clr_bits_c;
  logic             shift_c;
  logic             stop_c;
  logic             par_ok_c;

`ifdef UART_RX_PARITY_EN
  logic             par_bit;
  logic             par_c;
`endif

  // Two-flop synchronizer plus one history flop for edge detection. The fill
  // count keeps reset-forced ones from looking like a real high-to-low edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
      fill     <= 2'd0;
    end else begin
      rx_meta  <= usb_uart_rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
      if (fill != 2'd3) begin
        fill <= fill + 2'd1;
      end
    end
  end

  assign fall_c = (fill == 2'd3) && rxs_prev && !rxs;

  // Sample point: mid start bit in START, one full period later in every other busy state.
  always_comb begin
    sample_c = 1'b0;
    if (state == START) begin
      sample_c = (cnt == HALF_LAST);
    end else if (state != IDLE) begin
      sample_c = (cnt == FULL_LAST);
    end
  end

  // Bit-period counter, reloaded at every sample point so error never accumulates.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == IDLE) || sample_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fall_c) begin
          state_nxt = START;
        end
      end
      START: begin
        if (sample_c) begin
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample_c && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_c) begin
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (sample_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    clr_bits_c = 1'b0;
    shift_c    = 1'b0;
    stop_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_c      = 1'b0;
`endif
    case (state)
      IDLE:    clr_bits_c = fall_c;
      DATA:    shift_c    = sample_c;
`ifdef UART_RX_PARITY_EN
      PARITY:  par_c      = sample_c;
`endif
      STOP:    stop_c     = sample_c;
      default: ;
    endcase
  end

  // Data shift register and bit index; bits arrive LSB first so shift right.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else if (clr_bits_c) begin
      bit_idx <= 3'd0;
    end else if (shift_c) begin
      bit_idx <= bit_idx + 3'd1;
      shift   <= {rxs, shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit for the even-parity check at the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit <= 1'b0;
    end else if (par_c) begin
      par_bit <= rxs;
    end
  end

  assign par_ok_c = ~(^{shift, par_bit});
`else
  assign par_ok_c = 1'b1;
`endif

  // Holding register, handshake and status pulses; framing beats parity, a full
  // un-accepted holding register turns a good byte into an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      busy       <= (state_nxt != IDLE);
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (stop_c) begin
        if (!rxs) begin
          frame_err <= 1'b1;
        end else if (!par_ok_c) begin
          parity_err <= 1'b1;
        end else if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table, hand-written corner sequences and randomized
// frames against a byte-level model of the receiver and its holding register.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Pin falls during cycle p: rxs low at p+2, rx_valid first high at p+3+H+NB*C.
  localparam int LAT   = 3 + H + NB * C;
  localparam int FBUSY = H + NB * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       usb_uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .reset        (reset),
    .usb_uart_rxd (usb_uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .busy         (busy),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         n_vrise = 0, n_vhigh = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  int         n_busy = 0, n_unstable = 0, last_rise = 0;
  logic       v_prev = 1'b0, hs_prev = 1'b0;
  logic [7:0] d_prev = 8'h00;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (rx_valid && !v_prev) begin
      n_vrise++;
      last_rise = cyc;
    end
    if (rx_valid && v_prev && !hs_prev && (rx_data !== d_prev)) n_unstable++;
    if (rx_valid)   n_vhigh++;
    if (frame_err)  n_ferr++;
    if (overrun)    n_ovr++;
    if (parity_err) n_perr++;
    if (busy)       n_busy++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    hs_prev = rx_valid && rx_ready;
    v_prev  = rx_valid;
    d_prev  = rx_data;
  end

  typedef struct {
    int vrise, vhigh, ferr, ovr, perr, busy, got;
  } snap_t;

  function automatic snap_t snap();
    snap_t s;
    s.vrise = n_vrise; s.vhigh = n_vhigh; s.ferr = n_ferr; s.ovr = n_ovr;
    s.perr  = n_perr;  s.busy  = n_busy;  s.got  = got_q.size();
    return s;
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [7:0] exp);
    if (got_q.size() > idx) check(name, got_q[idx], exp);
    else check({name, "_missing"}, got_q.size(), idx + 1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame; a low stop bit can be stretched into a break by tail_low.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int tail_low,
                            output int p);
    usb_uart_rxd = 1'b0;
    p = cyc;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      usb_uart_rxd = d[i];
      tick(C);
    end
`ifdef UART_RX_PARITY_EN
    usb_uart_rxd = (^d) ^ par_flip;
    tick(C);
`endif
    usb_uart_rxd = stop;
    tick(C + (stop ? 0 : tail_low));
    usb_uart_rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         glitch;
    int         exp_valid;
    int         exp_ferr;
    int         exp_busy;
  } vec_t;

  vec_t       vt[6];
  snap_t      s;
  int         p;
  logic [7:0] exp_q[$];
  logic       full;
  logic [7:0] hold;
  logic [7:0] rd;
  logic       good, rdy;
  int         e_ferr, e_ovr, gap;

  initial begin
    vt[0] = '{8'hA5, 1'b1, 0, 1, 0, FBUSY};
    vt[1] = '{8'h00, 1'b1, 4, 0, 0, H};
    vt[2] = '{8'h3C, 1'b0, 0, 0, 1, FBUSY};
    vt[3] = '{8'h5A, 1'b1, 0, 1, 0, FBUSY};
    vt[4] = '{8'h00, 1'b1, 0, 1, 0, FBUSY};
    vt[5] = '{8'hFF, 1'b1, 0, 1, 0, FBUSY};

    // Reset state
    tick(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    reset = 1'b0;
    rx_ready = 1'b1;
    tick(10);

    // Directed table: frames and a false start, consumer always ready
    for (int i = 0; i < 6; i++) begin
      s = snap();
      if (vt[i].glitch > 0) begin
        usb_uart_rxd = 1'b0;
        tick(vt[i].glitch);
        usb_uart_rxd = 1'b1;
        tick(40);
      end else begin
        send_frame(vt[i].data, vt[i].stop, 0, p);
        tick(20);
      end
      check($sformatf("t%0d_valid_rise", i), n_vrise - s.vrise, vt[i].exp_valid);
      check($sformatf("t%0d_valid_cycles", i), n_vhigh - s.vhigh, vt[i].exp_valid);
      check($sformatf("t%0d_frame_err", i), n_ferr - s.ferr, vt[i].exp_ferr);
      check($sformatf("t%0d_busy_cycles", i), n_busy - s.busy, vt[i].exp_busy);
      if (vt[i].exp_valid != 0) begin
        check_got($sformatf("t%0d_data", i), s.got, vt[i].data);
        check($sformatf("t%0d_latency", i), last_rise - p, LAT);
      end
    end

    // Overrun: consumer stalled across two completed bytes
    rx_ready = 1'b0;
    s = snap();
    send_frame(8'h11, 1'b1, 0, p);
    tick(20);
    send_frame(8'h22, 1'b1, 0, p);
    tick(20);
    check("ovr_pulses", n_ovr - s.ovr, 1);
    check("ovr_valid_rise", n_vrise - s.vrise, 1);
    check("ovr_rx_valid", rx_valid, 1'b1);
    check("ovr_rx_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    tick(3);
    check("ovr_delivered", got_q.size() - s.got, 1);
    check_got("ovr_deliver_data", s.got, 8'h11);
    check("ovr_valid_cleared", rx_valid, 1'b0);

    // Reset during bit 3 of 0xFF, then a clean frame
    s = snap();
    usb_uart_rxd = 1'b0;
    tick(C);
    usb_uart_rxd = 1'b1;
    tick(3 * C + H);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_data", rx_data, 8'h00);
    tick(5 * C + 20);
    check("mid_rst_pulses", (n_ferr - s.ferr) + (n_ovr - s.ovr) + (n_perr - s.perr), 0);
    check("mid_rst_no_valid", n_vrise - s.vrise, 0);
    s = snap();
    send_frame(8'h81, 1'b1, 0, p);
    tick(20);
    check_got("post_rst_data", s.got, 8'h81);
    check("post_rst_latency", last_rise - p, LAT);

    // Break: stop low and line held low, no new frame until the line rises
    s = snap();
    send_frame(8'h3C, 1'b0, 3 * C, p);
    tick(10);
    check("break_frame_err", n_ferr - s.ferr, 1);
    check("break_busy_cycles", n_busy - s.busy, FBUSY);
    check("break_no_valid", n_vrise - s.vrise, 0);
    send_frame(8'h5A, 1'b1, 0, p);
    tick(20);
    check_got("after_break_data", s.got, 8'h5A);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 needs parity bit 1
    s = snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 0, p);
    tick(20);
    check("par_bad_err", n_perr - s.perr, 1);
    check("par_bad_no_valid", n_vrise - s.vrise, 0);
    send_frame(8'h07, 1'b0, 0, p);
    tick(20);
    check("par_and_stop_ferr", n_ferr - s.ferr, 1);
    check("par_and_stop_perr", n_perr - s.perr, 1);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 0, p);
    tick(20);
    check_got("par_good_data", s.got, 8'h07);
    s = snap();
`endif

    // Randomized frames against a byte-level holding-register model
    s = snap();
    full = 1'b0;
    hold = 8'h00;
    e_ferr = 0;
    e_ovr = 0;
    for (int k = 0; k < 40; k++) begin
      rd   = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      rdy  = 1'($urandom_range(0, 1));
      gap  = int'($urandom_range(4, 30));
      rx_ready = rdy;
      if (rdy && full) begin
        exp_q.push_back(hold);
        full = 1'b0;
      end
      send_frame(rd, good, 0, p);
      if (!good) e_ferr++;
      else if (!full) begin
        if (rdy) exp_q.push_back(rd);
        else begin
          full = 1'b1;
          hold = rd;
        end
      end else e_ovr++;
      tick(gap);
    end
    rx_ready = 1'b1;
    if (full) exp_q.push_back(hold);
    tick(4);
    check("rand_frame_err", n_ferr - s.ferr, e_ferr);
    check("rand_overrun", n_ovr - s.ovr, e_ovr);
    check("rand_count", got_q.size() - s.got, exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      check_got($sformatf("rand_byte%0d", j), s.got + j, exp_q[j]);
    end

`ifndef UART_RX_PARITY_EN
    check("parity_err_tied_low", n_perr, 0);
`endif
    check("rx_data_stable", n_unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 usb_uart_rxd  input  1  asynchronous serial line from the pin; idle high.
REQ-005 rx_data  output  8  received byte; stable while rx_valid high.
REQ-006 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 rx_ready  input  1  consumer accepts rx_data on a cycle with rx_valid && rx_ready.
REQ-008 busy  output  1  high whenever the frame state machine is not in IDLE.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
REQ-011 parity_err  output  1  one-cycle pulse: parity mismatch; see Configuration.

Function
REQ-012 usb_uart_rxd SHALL pass through a two-flop synchronizer; all decisions use the synchronized value rxs.
REQ-013 States: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 IDLE -> START on the cycle T0 on which rxs is low and was high the previous cycle; bit counter cleared.
REQ-015 START samples rxs at T0+CLKS_PER_BIT/2 (integer division); low -> DATA; high -> IDLE (false start), no outputs change.
REQ-016 DATA samples bit i (i=0..7, LSB first) at T0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT into a shift register.
REQ-017 Stop bit sampled at T0+CLKS_PER_BIT/2+9*CLKS_PER_BIT (10* with parity); FSM returns to IDLE on the sample cycle.
REQ-018 Stop low: frame_err pulses the next cycle, byte discarded, holding register untouched.
REQ-019 Stop high: byte complete; holding register loaded and rx_valid set the cycle after the stop sample, if rx_valid is low or rx_valid && rx_ready on that cycle.
REQ-020 Byte complete while rx_valid high and rx_ready low: new byte dropped, overrun pulses, rx_data and rx_valid unchanged.
REQ-021 rx_valid && rx_ready with no concurrent load: rx_valid clears next cycle.
REQ-022 A line held low after a framing error (break) SHALL NOT start a new frame until rxs returns high and falls again.
REQ-023 Bit-period counter width $clog2(CLKS_PER_BIT); counter reloads each sample point, no drift accumulation.

Reset
REQ-024 reset SHALL force state IDLE, counters 0, synchronizer flops 1, rx_data 0x00, rx_valid/busy/frame_err/overrun/parity_err 0, taking effect the cycle after assertion.
REQ-025 reset mid-frame SHALL abandon the frame with no output pulse; a new start is detected only after a high-to-low transition following reset release.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state inserted after DATA, even parity sampled at T0+CLKS_PER_BIT/2+9*CLKS_PER_BIT; mismatch pulses parity_err the cycle after the stop sample and discards the byte (frame_err takes precedence if both).
REQ-027 Macro undefined: 8N1 framing, no PARITY state, parity_err tied 0.

Verification (CLKS_PER_BIT=16)
REQ-028 8N1 byte 0xA5, rx_ready high -> rx_data=0xA5, rx_valid high exactly one cycle, rising at T0+8+144+1 relative to synchronized falling edge.
REQ-029 4-cycle low glitch on idle line -> busy high for 8 cycles, then IDLE; rx_valid, frame_err stay 0.
REQ-030 Byte 0x3C with stop bit low -> frame_err one pulse, rx_valid stays 0; following valid byte 0x5A after line high received correctly.
REQ-031 rx_ready low, bytes 0x11 then 0x22 -> rx_valid high with 0x11, overrun pulses once at second completion; raising rx_ready delivers 0x11 and clears rx_valid.
REQ-032 reset asserted during bit 3 of 0xFF -> no pulses, rx_valid 0; next frame 0x81 received correctly.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=0x07.
